// File: rtl/setting_display_pkg.sv
// setting_display_pkg: glyph codes, active-low segment patterns, default scan/blink dividers
// and the digit-content decode shared by the settings display.
package setting_display_pkg;

    typedef enum logic [3:0] {G_0, G_1, G_2, G_DASH, G_S, G_E, G_BLANK} glyph_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_S     = 8'h92;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int SCAN_DIV_DEF  = 50000;
    localparam int BLINK_DIV_DEF = 12500000;

    // digit3 = mode, digit2 = dash, digit1 = map (3 is illegal -> 'E'), digit0 = selecting flag
    function automatic glyph_t digit_code(input logic [1:0] idx, input logic mode,
                                          input logic [1:0] map, input logic sel);
        return idx == 2'd3 ? (mode ? G_1 : G_0) :
               idx == 2'd2 ? G_DASH :
               idx == 2'd1 ? (map == 2'd0 ? G_0 : map == 2'd1 ? G_1 : map == 2'd2 ? G_2 : G_E) :
               (sel ? G_S : G_BLANK);
    endfunction

endpackage

// File: rtl/setting_display_glyph.sv
// seg_glyph: combinational glyph code to active-low 7-segment pattern (dp off).
module seg_glyph
    import setting_display_pkg::*;
(
    input  glyph_t     code,
    output logic [7:0] seg
);

    always_comb begin
        seg = code == G_0    ? SEG_0    :
              code == G_1    ? SEG_1    :
              code == G_2    ? SEG_2    :
              code == G_DASH ? SEG_DASH :
              code == G_S    ? SEG_S    :
              code == G_E    ? SEG_E    : SEG_BLANK;
    end

endmodule

// File: rtl/setting_display.sv
// setting_display: multiplexed 4-digit 7-segment view of the settings state (mode, map, cursor).
// SETTING_BLINK_EN: cursor field blinks instead of lighting its decimal point.
module setting_display
    import setting_display_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cursor,
    input  logic       mode,
    input  logic [1:0] map,
    input  logic       selecting,
    output logic [3:0] seg_an,
    output logic [7:0] seg_cat
);

    localparam int SW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV and BLINK_DIV must be >= 2");
    end

    logic          s_cur, s_mode, s_sel;
    logic [1:0]    s_map;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic          scan_term, mark;
    glyph_t        code;
    logic [7:0]    glyph, cat_n;

    assign scan_term = scan_cnt == SW'(SCAN_DIV - 1);
    assign code      = digit_code(idx, s_mode, s_map, s_sel);
    assign mark      = s_sel && idx == (s_cur ? 2'd1 : 2'd3);

    seg_glyph u_glyph (.code(code), .seg(glyph));

`ifdef SETTING_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt;
    logic          phase;

    // Restart on cursor moves so the newly selected field is visible straight away
    always_ff @(posedge clk) begin
        if (rst || !s_sel || cursor != s_cur) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
            phase     <= blink_cnt == BW'(BLINK_DIV - 1) ? ~phase : phase;
        end
    end

    assign cat_n = mark && !phase ? SEG_BLANK : glyph;
`else
    assign cat_n = {glyph[7] & ~mark, glyph[6:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cur    <= 1'b0;
            s_mode   <= 1'b0;
            s_map    <= 2'd0;
            s_sel    <= 1'b0;
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg_an   <= 4'hF;
            seg_cat  <= 8'hFF;
        end else begin
            s_cur    <= cursor;
            s_mode   <= mode;
            s_map    <= map;
            s_sel    <= selecting;
            scan_cnt <= scan_term ? '0 : scan_cnt + 1'b1;
            idx      <= idx + {1'b0, scan_term};
            seg_an   <= ~(4'b0001 << idx);
            seg_cat  <= cat_n;
        end
    end

endmodule

// File: tb/tb_setting_display.sv
// tb_setting_display: table-driven digit content checks plus scan, reset and blink sequences.
module tb_setting_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cursor = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] map = 2'd0;
    logic       selecting = 1'b0;
    logic [3:0] seg_an;
    logic [7:0] seg_cat;

    int checks = 0;
    int errors = 0;

    setting_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .rst(rst), .cursor(cursor), .mode(mode), .map(map),
        .selecting(selecting), .seg_an(seg_an), .seg_cat(seg_cat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            mode;
        logic [1:0]      map;
        logic            cur;
        logic            sel;
        logic [3:0][7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic capture(input int d, output logic [7:0] cat);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << d);
        n = 0;
        while (seg_an !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: digit %0d anode never low, seg_an=%h", d, seg_an);
        end
        cat = seg_cat;
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] cat;
        logic [3:0] e;
        bit         on;

        vecs[0] = '{1'b1, 2'd2, 1'b0, 1'b0, {8'hF9, 8'hBF, 8'hA4, 8'hFF}};
        vecs[1] = '{1'b1, 2'd3, 1'b0, 1'b0, {8'hF9, 8'hBF, 8'h86, 8'hFF}};
        vecs[2] = '{1'b0, 2'd0, 1'b1, 1'b0, {8'hC0, 8'hBF, 8'hC0, 8'hFF}};
        vecs[3] = '{1'b0, 2'd1, 1'b0, 1'b1, {8'h40, 8'hBF, 8'hF9, 8'h92}};
        vecs[4] = '{1'b1, 2'd0, 1'b1, 1'b1, {8'hF9, 8'hBF, 8'h40, 8'h92}};
        vecs[5] = '{1'b1, 2'd2, 1'b0, 1'b1, {8'h79, 8'hBF, 8'hA4, 8'h92}};

        repeat (3) @(negedge clk);
        check("reset_an", seg_an, 4'hF);
        check("reset_cat", seg_cat, 8'hFF);

        rst = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            e = ~(4'b0001 << (((j - 1) / 4) % 4));
            check($sformatf("scan_step%0d", j), seg_an, e);
        end

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            map = vecs[i].map;
            cursor = vecs[i].cur;
            selecting = vecs[i].sel;
            repeat (3) @(negedge clk);
            for (int d = 3; d >= 0; d--) begin
`ifdef SETTING_BLINK_EN
                if (vecs[i].sel && d == (vecs[i].cur ? 1 : 3)) continue;
`endif
                capture(d, cat);
                check($sformatf("vec%0d_digit%0d", i, d), cat, vecs[i].exp[d]);
            end
        end

`ifdef SETTING_BLINK_EN
        mode = 1'b1;
        map = 2'd2;
        selecting = 1'b1;
        cursor = 1'b1;
        repeat (4) @(negedge clk);
        cursor = 1'b0;
        @(negedge clk);
        for (int j = 1; j <= 48; j++) begin
            @(negedge clk);
            on = ((j - 1) / 16) % 2 == 0;
            if (seg_an == 4'h7) check($sformatf("blink_d3_%0d", j), seg_cat, on ? 8'hF9 : 8'hFF);
            if (seg_an == 4'hE) check($sformatf("blink_d0_%0d", j), seg_cat, 8'h92);
        end
        repeat (8) @(negedge clk);
        cursor = 1'b1;
        capture(1, cat);
        check("blink_move_d1", cat, 8'hA4);
        capture(3, cat);
        check("blink_move_d3", cat, 8'hF9);
`endif

        mode = 1'b1;
        map = 2'd2;
        selecting = 1'b1;
        cursor = 1'b1;
        repeat (3) @(negedge clk);
        capture(1, cat);
        capture(2, cat);
        rst = 1'b1;
        @(negedge clk);
        check("midscan_rst_an", seg_an, 4'hF);
        check("midscan_rst_cat", seg_cat, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        check("restart_an", seg_an, 4'hE);
        capture(1, cat);
`ifdef SETTING_BLINK_EN
        check("restart_d1", cat, 8'hA4);
`else
        check("restart_d1", cat, 8'h24);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
